multi_divider: RTL

Parametrised successor to the fixed ten-output clock divider in the user project area. It generates NCH independent divided clock outputs from one core clock. Each channel has a runtime-programmable divisor, an enable, and glitch-free divisor updates. The block sits inside the user project wrapper, is clocked from the Wishbone clock, and drives its outputs onto user I/O pads.

---
 rtl/divider_pkg.sv | 24 ++
 rtl/div_channel.sv | 84 ++++++++
 rtl/multi_divider.sv | 54 +++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
package divider_pkg;

    localparam int DIV_CW_DEFAULT = 8;
    localparam int NCH_DEFAULT    = 10;
    localparam int DIV_CW_MAX     = 16;

    // Effective divisor: 0 means the channel is off, 1 is promoted to 2.
    function automatic logic [DIV_CW_MAX-1:0] eff_div(input logic [DIV_CW_MAX-1:0] d);
        logic [DIV_CW_MAX-1:0] e;
        if (d == '0)
            e = '0;
        else if (d == DIV_CW_MAX'(1))
            e = DIV_CW_MAX'(2);
        else
            e = d;
        return e;
    endfunction

    function automatic logic [DIV_CW_MAX-1:0] rst_div(input int i);
        return DIV_CW_MAX'(2 * (i + 1));
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, active/pending divisor and registered clock output.
// Optional terminal-count pulse output when DIVIDER_TICK_EN is defined.
module div_channel
    import divider_pkg::*;
#(
    parameter int CW  = DIV_CW_DEFAULT,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    output logic          pend_v,
    output logic          cout
`ifdef DIVIDER_TICK_EN
    ,output logic         tick
`endif
);

    localparam logic [CW-1:0] RST_DIV = CW'(rst_div(IDX));

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] div_reg;
    logic [CW-1:0] pend_reg;
    logic          pend_v_reg;
    logic          cout_reg;
    logic [CW-1:0] e;
    logic          running;
    logic          tc;

    assign e       = CW'(eff_div(DIV_CW_MAX'(div_reg)));
    assign running = en && (div_reg != '0);
    assign tc      = running && (cnt_reg == e - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            div_reg    <= RST_DIV;
            pend_reg   <= '0;
            pend_v_reg <= 1'b0;
            cout_reg   <= 1'b0;
        end else if (!running) begin
            // Idle channel: any new or pending divisor takes effect immediately.
            cnt_reg  <= '0;
            cout_reg <= 1'b0;
            if (wr)
                div_reg <= wr_div;
            else if (pend_v_reg)
                div_reg <= pend_reg;
            pend_v_reg <= 1'b0;
        end else begin
            cout_reg <= (cnt_reg < (e >> 1));
            cnt_reg  <= tc ? '0 : cnt_reg + CW'(1);
            if (tc) begin
                if (wr)
                    div_reg <= wr_div;
                else if (pend_v_reg)
                    div_reg <= pend_reg;
                pend_v_reg <= 1'b0;
            end else if (wr) begin
                pend_reg   <= wr_div;
                pend_v_reg <= 1'b1;
            end
        end
    end

`ifdef DIVIDER_TICK_EN
    logic tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_reg <= 1'b0;
        else
            tick_reg <= tc;
    end

    assign tick = tick_reg;
`endif

    assign pend_v = pend_v_reg;
    assign cout   = cout_reg;

endmodule

// File: rtl/multi_divider.sv
// NCH independent programmable clock dividers with a shared divisor write port.
// Define DIVIDER_TICK_EN to add the per-channel terminal-count pulse outputs.
module multi_divider
    import divider_pkg::*;
#(
    parameter int  NCH = NCH_DEFAULT,
    parameter int  CW  = DIV_CW_DEFAULT,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] cout
`ifdef DIVIDER_TICK_EN
    ,output logic [NCH-1:0] tick
`endif
);

    logic [NCH-1:0]      pend_v;
    // Padded to the full index range so out-of-range channels read as never busy.
    logic [2**CHW-1:0]   pend_ext;
    logic                cfg_fire;

    assign cfg_ready = !pend_ext[cfg_ch];
    assign cfg_fire  = cfg_valid && cfg_ready;

    for (genvar gi = 0; gi < 2**CHW; gi++) begin : g_chan
        if (gi < NCH) begin : g_real
            div_channel #(
                .CW  (CW),
                .IDX (gi)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (en[gi]),
                .wr     (cfg_fire && (cfg_ch == CHW'(gi))),
                .wr_div (cfg_div),
                .pend_v (pend_v[gi]),
                .cout   (cout[gi])
`ifdef DIVIDER_TICK_EN
                ,.tick  (tick[gi])
`endif
            );
            assign pend_ext[gi] = pend_v[gi];
        end else begin : g_pad
            assign pend_ext[gi] = 1'b0;
        end
    end

endmodule
